// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} arb_state_t;
  localparam int unsigned DATA_W_DEF = 8;
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after 'last', wrapping mod N_REQ.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    next
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  int unsigned        base;
  int unsigned        pos;
  int unsigned        sum;

  always_comb begin
    // Rotate so bit 0 is the requester after 'last', priority-encode, then un-rotate.
    base  = 32'(last) + 1;
    dbl   = {req, req};
    rot   = N_REQ'(dbl >> base);
    pos   = 0;
    valid = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[i] && !valid) begin
        pos   = i;
        valid = 1'b1;
      end
    end
    sum = base + pos;
    if (sum >= N_REQ) sum = sum - N_REQ;
    next = IW'(sum);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers,
// with bounded bursts per grant and FIFO-full back-pressure.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          ack,
  input  logic                      fifo_full,
  output logic                      fifo_wr,
  output logic [DATA_W-1:0]         fifo_din,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  owner
);
  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  arb_state_t     state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pick_valid;
  logic [IW-1:0]  pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req),
    .last  (owner_q),
    .valid (pick_valid),
    .next  (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= IW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    fifo_wr = 1'b0;
    ack     = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (!fifo_full) begin
          fifo_wr      = 1'b1;
          ack[owner_q] = 1'b1;
          if (cnt_q == CW'(MAX_BURST - 1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == BURST);
  assign owner    = owner_q;
  assign fifo_din = wdata[owner_q*DATA_W +: DATA_W];
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: behavioural model, per-requester scoreboard and a queue-based FIFO.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 31;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ack;
  logic            fifo_full = 1'b0;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_din;
  logic            busy;
  logic [1:0]      owner;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .ack       (ack),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din),
    .busy      (busy),
    .owner     (owner)
  );

  logic [7:0] fq[$];
  logic       rd = 1'b0;
  logic       drain = 1'b0;

  always @(posedge clk) begin
    if (fifo_wr && !fifo_full) fq.push_back(fifo_din);
    if ((rd || drain) && fq.size() > 0) void'(fq.pop_front());
    fifo_full <= (fq.size() >= DEPTH);
  end

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endfunction

  int         en[N];
  int         left[N];
  int         seq[N];
  logic [N-1:0] ack_seen = '0;

  task automatic drive_update();
    for (int i = 0; i < N; i++) begin
      req[i] = (en[i] != 0) && (left[i] > 0);
      wdata[i*DW +: DW] = {2'(i), 6'(seq[i])};
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i]) begin
        seq[i]++;
        left[i]--;
      end
    end
    drive_update();
  endtask

  // Model: an open grant has an owner and a number of words still allowed.
  int   m_busy = 0;
  int   m_owner = N - 1;
  int   m_left = 0;
  int   sb[N];
  int   grant_q[$];
  int   words_q[$];
  logic prev_busy = 1'b0;
  logic e_wr;

  always @(negedge rst_n) begin
    m_busy  = 0;
    m_owner = N - 1;
    m_left  = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy    = 0;
      m_owner   = N - 1;
      m_left    = 0;
      ack_seen  = '0;
      prev_busy = 1'b0;
    end else begin
      e_wr = (m_busy != 0) && req[m_owner] && !fifo_full;
      chk("busy", int'(busy), m_busy);
      chk("owner", int'(owner), m_owner);
      chk("fifo_wr", int'(fifo_wr), int'(e_wr));
      chk("ack", int'(ack), e_wr ? (1 << m_owner) : 0);
      if (m_busy != 0) chk("fifo_din", int'(fifo_din), int'(wdata[m_owner*DW +: DW]));
      chk("wr_in_idle", int'(fifo_wr & ~busy), 0);
      if (fifo_wr) begin
        chk("sb_order", int'(fifo_din), int'({owner, 6'(sb[owner])}));
        sb[owner]++;
      end
      if (busy && !prev_busy) begin
        grant_q.push_back(int'(owner));
        words_q.push_back(0);
      end
      if (ack != '0 && words_q.size() > 0) words_q[words_q.size()-1]++;
      prev_busy = busy;
      ack_seen  = ack;
      if (m_busy == 0) begin
        if (req != '0) begin
          for (int k = 1; k <= N; k++) begin
            if (m_busy == 0 && req[(m_owner + k) % N]) begin
              m_owner = (m_owner + k) % N;
              m_busy  = 1;
            end
          end
          m_left = MB;
        end
      end else if (!req[m_owner]) begin
        m_busy = 0;
      end else if (e_wr) begin
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end
  end

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < N; i++) if (en[i] != 0 && left[i] > 0) p = 1;
    return p;
  endfunction

  task automatic run_until_done(string nm, int budget);
    int n = 0;
    while (n < budget && pending() != 0) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    chk({nm, "_done"}, pending(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i]   = 0;
      left[i] = 0;
    end
    drain = 1'b0;
    rd    = 1'b0;
    drive_update();
    fq.delete();
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_wr", int'(fifo_wr), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_owner", int'(owner), N - 1);
    cyc();
    cyc();
    grant_q.delete();
    words_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  logic [8:0] hist;

  initial begin
    for (int i = 0; i < N; i++) begin
      en[i] = 0; left[i] = 0; seq[i] = 0; sb[i] = 0;
    end
    drive_update();
    do_reset();

    // 1: single requester, 6 words -> 4, bubble, 2
    en[0] = 1; left[0] = 6; drive_update();
    hist = '0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      hist = {hist[7:0], ack[0]};
      cyc();
    end
    chk("t1_ack_pattern", int'(hist), 'b011110110);
    chk("t1_fifo_count", fq.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (fq.size() > 0) chk("t1_fifo_word", int'(fq.pop_front()), k);
      else chk("t1_fifo_word", -1, k);
    end

    // 2: all four streaming
    do_reset();
    drain = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1; left[i] = 12;
    end
    drive_update();
    run_until_done("t2", 400);
    chk("t2_grants", grant_q.size(), 12);
    for (int g = 0; g < 12 && g < grant_q.size(); g++) begin
      chk("t2_grant_order", grant_q[g], g % N);
      chk("t2_words_per_grant", words_q[g], MB);
    end

    // 3: FIFO nearly full
    do_reset();
    for (int k = 0; k < 30; k++) fq.push_back(8'hEE);
    cyc();
    en[2] = 1; left[2] = 6; drive_update();
    cyc();
    cyc();
    chk("t3_fifo_count", fq.size(), 31);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_full", int'(fifo_full), 1);
      chk("t3_busy_held", int'(busy), 1);
      chk("t3_wr_blocked", int'(fifo_wr), 0);
      cyc();
    end
    rd = 1'b1;
    cyc();
    cyc();
    rd = 1'b0;
    drain = 1'b1;
    run_until_done("t3", 100);
    chk("t3_grants", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      chk("t3_owner", grant_q[0], 2);
      chk("t3_burst_total", words_q[0], MB);
      chk("t3_second_burst", words_q[1], 2);
    end

    // 4: requester 1 drops after 2 acks while 3 waits
    do_reset();
    drain = 1'b1;
    en[1] = 1; left[1] = 2;
    en[3] = 1; left[3] = 4;
    drive_update();
    run_until_done("t4", 100);
    chk("t4_grants", grant_q.size(), 2);
    if (grant_q.size() >= 2) begin
      chk("t4_first_owner", grant_q[0], 1);
      chk("t4_first_words", words_q[0], 2);
      chk("t4_second_owner", grant_q[1], 3);
      chk("t4_second_words", words_q[1], 4);
    end

    // 5: asynchronous reset mid-burst
    do_reset();
    drain = 1'b1;
    en[2] = 1; left[2] = 10; drive_update();
    for (int n = 0; n < 50 && !(words_q.size() > 0 && words_q[0] >= 2); n++) cyc();
    chk("t5_reached_burst", int'(words_q.size() > 0 && words_q[0] >= 2), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_wr_async", int'(fifo_wr), 0);
    chk("t5_busy_async", int'(busy), 0);
    chk("t5_ack_async", int'(ack), 0);
    chk("t5_owner_async", int'(owner), N - 1);
    en[2] = 0; left[2] = 0;
    en[3] = 1; left[3] = 3;
    drive_update();
    grant_q.delete();
    words_q.delete();
    #1;
    rst_n = 1'b1;
    run_until_done("t5", 100);
    chk("t5_grants", grant_q.size(), 1);
    if (grant_q.size() >= 1) begin
      chk("t5_first_owner", grant_q[0], 3);
      chk("t5_words", words_q[0], 3);
    end

    // 6: 0 and 2 requesting, 0 re-requests immediately
    do_reset();
    drain = 1'b1;
    en[0] = 1; left[0] = 8;
    en[2] = 1; left[2] = 4;
    drive_update();
    run_until_done("t6", 100);
    chk("t6_grants", grant_q.size(), 3);
    if (grant_q.size() >= 3) begin
      chk("t6_g0", grant_q[0], 0);
      chk("t6_g1", grant_q[1], 2);
      chk("t6_g2", grant_q[2], 0);
      for (int g = 0; g < 3; g++) chk("t6_words", words_q[g], MB);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
